// File: rtl/axis_1553_arbiter.sv
// axis_1553_arbiter -- message-granular round-robin arbiter. It merges
// NUM_REQ AXI-Stream requesters onto one 1553 encoder stream.
//
// Parameters
//   NUM_REQ    : number of requesters (2..8)
//   GAP_CYCLES : quiet time after each message, in aclk cycles (1..65535)
//
// Ports
//   aclk, arstn            : clock; synchronous active-low reset
//   s_axis_tdata/tuser     : per-requester word / flags (16 / 8 bits per slice)
//   s_axis_tvalid/tlast    : per-requester valid / end-of-message
//   s_axis_tready          : per-requester ready (only the owner ever sees ready)
//   m_axis_tdata/tuser     : granted word / flags to the encoder
//   m_axis_tvalid/tready   : handshake with the encoder
//   grant                  : registered one-hot owner, zero when the bus is free
//   busy                   : FSM is not IDLE
//
// Build option
//   AXIS_1553_ARB_GAP_EN : when defined, a GAP state holds the bus quiet for
//                          GAP_CYCLES cycles after every tlast beat. When it is
//                          undefined, tlast returns straight to IDLE.

module axis_1553_arb_lane (
  input  logic        gnt,
  input  logic        pass,
  input  logic        m_tready,
  input  logic        s_tvalid,
  input  logic [15:0] s_tdata,
  input  logic [7:0]  s_tuser,
  output logic        s_tready,
  output logic        lane_tvalid,
  output logic [15:0] lane_tdata,
  output logic [7:0]  lane_tuser
);
  logic sel;
  assign sel         = gnt & pass;
  assign s_tready    = sel & m_tready;
  assign lane_tvalid = sel & s_tvalid;
  assign lane_tdata  = sel ? s_tdata : '0;
  assign lane_tuser  = sel ? s_tuser : '0;
endmodule

module axis_1553_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int GAP_CYCLES = 80
) (
  input  logic                  aclk,
  input  logic                  arstn,
  input  logic [NUM_REQ*16-1:0] s_axis_tdata,
  input  logic [NUM_REQ*8-1:0]  s_axis_tuser,
  input  logic [NUM_REQ-1:0]    s_axis_tvalid,
  input  logic [NUM_REQ-1:0]    s_axis_tlast,
  output logic [NUM_REQ-1:0]    s_axis_tready,
  output logic [15:0]           m_axis_tdata,
  output logic [7:0]            m_axis_tuser,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [NUM_REQ-1:0]    grant,
  output logic                  busy
);
  localparam int IW = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("NUM_REQ must be 2..8");
  end
  if (GAP_CYCLES < 1 || GAP_CYCLES > 65535) begin : g_bad_gap
    $error("GAP_CYCLES must be 1..65535");
  end

`ifdef AXIS_1553_ARB_GAP_EN
  localparam int CW = $clog2(GAP_CYCLES + 1);
  typedef enum logic [1:0] {IDLE = 2'd0, PASS = 2'd1, GAP = 2'd2} state_t;
  logic [CW-1:0] gap_cnt;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, PASS = 2'd1} state_t;
`endif

  state_t state, state_d;
  logic [NUM_REQ-1:0] grant_q;
  logic [IW-1:0]      owner_q, last_owner, rr_sel;
  logic               rr_hit, pass, xfer, xfer_last;
  int                 rr_idx;

  logic [NUM_REQ-1:0]       lane_tvalid;
  logic [NUM_REQ-1:0][15:0] lane_tdata;
  logic [NUM_REQ-1:0][7:0]  lane_tuser;

  // Only the owner lane is ever enabled, so an OR across lanes acts as the mux.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    axis_1553_arb_lane u_lane (
      .gnt         (grant_q[i]),
      .pass        (pass),
      .m_tready    (m_axis_tready),
      .s_tvalid    (s_axis_tvalid[i]),
      .s_tdata     (s_axis_tdata[i*16 +: 16]),
      .s_tuser     (s_axis_tuser[i*8 +: 8]),
      .s_tready    (s_axis_tready[i]),
      .lane_tvalid (lane_tvalid[i]),
      .lane_tdata  (lane_tdata[i]),
      .lane_tuser  (lane_tuser[i])
    );
  end

  assign xfer      = m_axis_tvalid & m_axis_tready;
  assign xfer_last = xfer & (|(grant_q & s_axis_tlast));
  assign grant     = grant_q;

  // Round robin: first valid requester strictly after last_owner, with wrap.
  always_comb begin
    rr_hit = 1'b0;
    rr_sel = last_owner;
    rr_idx = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      rr_idx = (int'(last_owner) + k) % NUM_REQ;
      if (!rr_hit && s_axis_tvalid[rr_idx[IW-1:0]]) begin
        rr_hit = 1'b1;
        rr_sel = rr_idx[IW-1:0];
      end
    end
  end

  // State register
  always_ff @(posedge aclk) begin
    if (!arstn) state <= IDLE;
    else        state <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state;
    unique case (state)
      IDLE: if (rr_hit) state_d = PASS;
`ifdef AXIS_1553_ARB_GAP_EN
      PASS: if (xfer_last) state_d = GAP;
      GAP:  if (gap_cnt == '0) state_d = IDLE;
`else
      PASS: if (xfer_last) state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase
  end

  // Outputs. Gating on arstn keeps everything low while reset is held,
  // including before the first reset edge has been seen.
  always_comb begin
    pass         = arstn && (state == PASS);
    busy         = arstn && (state != IDLE);
    m_axis_tvalid = |lane_tvalid;
    m_axis_tdata  = '0;
    m_axis_tuser  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      m_axis_tdata = m_axis_tdata | lane_tdata[i];
      m_axis_tuser = m_axis_tuser | lane_tuser[i];
    end
  end

  // Ownership bookkeeping
  always_ff @(posedge aclk) begin
    if (!arstn) begin
      grant_q    <= '0;
      owner_q    <= '0;
      last_owner <= IW'(NUM_REQ - 1);
    end else if (state == IDLE && rr_hit) begin
      grant_q <= {{(NUM_REQ-1){1'b0}}, 1'b1} << rr_sel;
      owner_q <= rr_sel;
    end else if (xfer_last) begin
      grant_q    <= '0;
      last_owner <= owner_q;
    end
  end

`ifdef AXIS_1553_ARB_GAP_EN
  // Loaded with GAP_CYCLES-1 on the tlast edge; GAP exits at zero, so the
  // FSM spends exactly GAP_CYCLES cycles in GAP.
  always_ff @(posedge aclk) begin
    if (!arstn)                           gap_cnt <= '0;
    else if (xfer_last)                   gap_cnt <= CW'(GAP_CYCLES - 1);
    else if (state == GAP && gap_cnt != '0) gap_cnt <= gap_cnt - CW'(1);
  end
`endif

endmodule

// File: tb/tb_axis_1553_arbiter.sv
module tb_axis_1553_arbiter;
  localparam int NR = 4;
  localparam int GC = 80;
`ifdef AXIS_1553_ARB_GAP_EN
  localparam int GAPX = GC;
`else
  localparam int GAPX = 0;
`endif

  logic            tb_data_clk = 1'b0;
  logic            arstn;
  logic [NR*16-1:0] s_axis_tdata;
  logic [NR*8-1:0] s_axis_tuser;
  logic [NR-1:0]   s_axis_tvalid, s_axis_tlast, s_axis_tready, grant;
  logic [15:0]     m_axis_tdata;
  logic [7:0]      m_axis_tuser;
  logic            m_axis_tvalid, m_axis_tready, busy;

  int tests = 0;
  int fails = 0;

  always #5 tb_data_clk = ~tb_data_clk;

  axis_1553_arbiter #(.NUM_REQ(NR), .GAP_CYCLES(GC)) dut (
    .aclk          (tb_data_clk),
    .arstn         (arstn),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .grant         (grant),
    .busy          (busy)
  );

  typedef struct {
    logic [NR-1:0] mask;
    logic [NR-1:0] eg;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Inputs are driven 2 units after the rising edge, outputs sampled 1 unit later.
  task automatic tick();
    @(posedge tb_data_clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_in();
    s_axis_tdata  = '0;
    s_axis_tuser  = '0;
    s_axis_tvalid = '0;
    s_axis_tlast  = '0;
    m_axis_tready = 1'b0;
  endtask

  task automatic do_reset(input int n);
    clear_in();
    arstn = 1'b0;
    repeat (n) tick();
    arstn = 1'b1;
  endtask

  function automatic int rr(input int lo, input logic [NR-1:0] m);
    for (int k = 1; k <= NR; k++)
      if (m[(lo + k) % NR]) return (lo + k) % NR;
    return -1;
  endfunction

  // One message from requester r starting with the bus idle. Cycle 0 is the
  // arbitration cycle; from cycle 1 on the owner's tready must follow m_axis_tready.
  task automatic run_msg(input int r, input int n, input logic [3:0][15:0] wv, input bit toggle);
    int k, c;
    logic [NR-1:0] et;
    k = 0;
    c = 0;
    s_axis_tvalid = '0;
    s_axis_tvalid[r] = 1'b1;
    while (k < n && c < 40) begin
      m_axis_tready = toggle ? c[0] : 1'b1;
      s_axis_tdata[r*16 +: 16] = wv[k];
      s_axis_tuser[r*8 +: 8]   = 8'h8F;
      s_axis_tlast[r]          = (k == n - 1);
      settle();
      et = '0;
      if (c != 0) et[r] = m_axis_tready;
      chk("msg_s_tready", 32'(s_axis_tready), 32'(et));
      if (m_axis_tvalid && m_axis_tready) begin
        chk("msg_tdata", 32'(m_axis_tdata), 32'(wv[k]));
        chk("msg_tuser", 32'(m_axis_tuser), 32'h8F);
        chk("msg_grant", 32'(grant), 32'(1 << r));
        k++;
      end
      tick();
      c++;
    end
    chk("msg_words", 32'(k), 32'(n));
    s_axis_tvalid = '0;
    s_axis_tlast  = '0;
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[13];
    logic [3:0][15:0] wv;
    int n;

    tbl[0]  = '{4'b1111, 4'b0001};
    tbl[1]  = '{4'b1111, 4'b0010};
    tbl[2]  = '{4'b1111, 4'b0100};
    tbl[3]  = '{4'b1111, 4'b1000};
    tbl[4]  = '{4'b1111, 4'b0001};
    tbl[5]  = '{4'b1010, 4'b0010};
    tbl[6]  = '{4'b1010, 4'b1000};
    tbl[7]  = '{4'b1010, 4'b0010};
    tbl[8]  = '{4'b0001, 4'b0001};
    tbl[9]  = '{4'b0001, 4'b0001};
    tbl[10] = '{4'b1100, 4'b0100};
    tbl[11] = '{4'b0110, 4'b0010};
    tbl[12] = '{4'b1000, 4'b1000};

    // Reset held with every requester valid
    clear_in();
    arstn = 1'b0;
    s_axis_tvalid = '1;
    s_axis_tlast  = '1;
    m_axis_tready = 1'b1;
    for (int i = 0; i < NR; i++) s_axis_tdata[i*16 +: 16] = 16'hC000 + 16'(i);
    repeat (5) begin
      tick();
      settle();
      chk("rst_grant", 32'(grant), 32'h0);
      chk("rst_s_tready", 32'(s_axis_tready), 32'h0);
      chk("rst_m_tvalid", 32'(m_axis_tvalid), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
    end
    chk("rst_m_tdata", 32'(m_axis_tdata), 32'h0);
    chk("rst_m_tuser", 32'(m_axis_tuser), 32'h0);
    arstn = 1'b1;
    tick();
    settle();
    chk("post_rst_grant", 32'(grant), 32'h1);
    chk("post_rst_tdata", 32'(m_axis_tdata), 32'hC000);

    // Three-word message from requester 1, then the gap
    do_reset(2);
    wv = '{16'h0, 16'h0002, 16'h0001, 16'h1234};
    run_msg(1, 3, wv, 1'b0);
    settle();
    chk("after_tlast_grant", 32'(grant), 32'h0);
    n = 0;
    while (busy && n < 300) begin
      tick();
      settle();
      n++;
    end
    chk("gap_len", 32'(n), 32'(GAPX));

    // Encoder backpressure toggling every cycle
    do_reset(2);
    wv = '{16'h2D04, 16'h2C03, 16'h2B02, 16'h2A01};
    run_msg(2, 4, wv, 1'b1);

    // Round-robin table, one-word messages
    do_reset(2);
    for (int r = 0; r < 13; r++) begin
      int j;
      j = 0;
      for (int i = 0; i < NR; i++) if (tbl[r].eg[i]) j = i;
      s_axis_tvalid = tbl[r].mask;
      s_axis_tlast  = '1;
      m_axis_tready = 1'b1;
      for (int i = 0; i < NR; i++) s_axis_tdata[i*16 +: 16] = 16'h5000 + 16'(r*16 + i);
      settle();
      n = 0;
      while (grant == '0 && n < 10) begin
        tick();
        settle();
        n++;
      end
      chk("tbl_grant", 32'(grant), 32'(tbl[r].eg));
      chk("tbl_m_tvalid", 32'(m_axis_tvalid), 32'h1);
      chk("tbl_tdata", 32'(m_axis_tdata), 32'(16'h5000 + 16'(r*16 + j)));
      tick();
      s_axis_tvalid = '0;
      settle();
      chk("tbl_grant_clr", 32'(grant), 32'h0);
      n = 0;
      while (busy && n < 300) begin
        tick();
        settle();
        n++;
      end
    end

    // Reset during beat 2 of a message from requester 3
    do_reset(2);
    s_axis_tvalid[3] = 1'b1;
    s_axis_tdata[3*16 +: 16] = 16'h3000;
    m_axis_tready = 1'b1;
    tick();
    settle();
    chk("abort_beat1", 32'(m_axis_tdata), 32'h3000);
    tick();
    s_axis_tdata[3*16 +: 16] = 16'h3001;
    arstn = 1'b0;
    settle();
    chk("abort_in_rst_tvalid", 32'(m_axis_tvalid), 32'h0);
    chk("abort_in_rst_tready", 32'(s_axis_tready), 32'h0);
    tick();
    settle();
    chk("abort_grant", 32'(grant), 32'h0);
    chk("abort_busy", 32'(busy), 32'h0);
    s_axis_tvalid = '1;
    arstn = 1'b1;
    tick();
    settle();
    chk("abort_regrant", 32'(grant), 32'h1);

    // Back-to-back spacing between two 2-word messages
    do_reset(2);
    begin
      int idx[2];
      int t0, t1, cyc;
      logic [15:0] got[$];
      idx[0] = 0; idx[1] = 0;
      t0 = -1; t1 = -1; cyc = 0;
      m_axis_tready = 1'b1;
      while ((idx[0] < 2 || idx[1] < 2) && cyc < 400) begin
        for (int r = 0; r < 2; r++) begin
          s_axis_tvalid[r] = (idx[r] < 2);
          s_axis_tdata[r*16 +: 16] = (r == 0 ? 16'hA000 : 16'hB100) + 16'(idx[r]);
          s_axis_tlast[r] = (idx[r] == 1);
        end
        settle();
        if (m_axis_tvalid && m_axis_tready) begin
          got.push_back(m_axis_tdata);
          if (m_axis_tdata == 16'hA001) t0 = cyc;
          if (m_axis_tdata == 16'hB100) t1 = cyc;
        end
        for (int r = 0; r < 2; r++)
          if (s_axis_tvalid[r] && s_axis_tready[r]) idx[r]++;
        tick();
        cyc++;
      end
      s_axis_tvalid = '0;
      chk("b2b_done", 32'(cyc < 400), 32'h1);
      chk("b2b_spacing", 32'(t1 - t0), 32'(GAPX + 2));
      chk("b2b_count", 32'(got.size()), 32'h4);
      if (got.size() == 4) begin
        chk("b2b_w0", 32'(got[0]), 32'hA000);
        chk("b2b_w1", 32'(got[1]), 32'hA001);
        chk("b2b_w2", 32'(got[2]), 32'hB100);
        chk("b2b_w3", 32'(got[3]), 32'hB101);
      end
    end

    // Random traffic against a timeline model of ownership
    do_reset(2);
    begin
      logic [15:0] cw[NR];
      logic [7:0]  cu[NR];
      int left[NR];
      bit v[NR];
      int mown, mlo, free_at;
      logic [NR-1:0] vm, et, eg;
      bit lastw;
      mown = -1; mlo = NR - 1; free_at = 0;
      for (int i = 0; i < NR; i++) begin
        cw[i] = '0; cu[i] = '0; left[i] = 0; v[i] = 1'b0;
      end
      for (int cyc = 0; cyc < 2500; cyc++) begin
        for (int i = 0; i < NR; i++) begin
          if (!v[i] && $urandom_range(0, 3) == 0) begin
            v[i] = 1'b1;
            if (left[i] == 0) left[i] = $urandom_range(1, 4);
            cw[i] = 16'($urandom);
            cu[i] = 8'($urandom);
          end
          s_axis_tvalid[i] = v[i];
          s_axis_tdata[i*16 +: 16] = cw[i];
          s_axis_tuser[i*8 +: 8] = cu[i];
          s_axis_tlast[i] = (left[i] == 1);
        end
        m_axis_tready = ($urandom_range(0, 3) != 0);
        settle();
        vm = '0;
        for (int i = 0; i < NR; i++) vm[i] = v[i];
        eg = '0;
        et = '0;
        if (mown >= 0) begin
          eg[mown] = 1'b1;
          et[mown] = m_axis_tready;
        end
        chk("rnd_grant", 32'(grant), 32'(eg));
        chk("rnd_busy", 32'(busy), 32'(mown >= 0 || cyc < free_at));
        chk("rnd_m_tvalid", 32'(m_axis_tvalid), 32'(mown >= 0 && v[mown]));
        chk("rnd_s_tready", 32'(s_axis_tready), 32'(et));
        if (mown >= 0 && v[mown] && m_axis_tready) begin
          chk("rnd_tdata", 32'(m_axis_tdata), 32'(cw[mown]));
          chk("rnd_tuser", 32'(m_axis_tuser), 32'(cu[mown]));
          lastw = (left[mown] == 1);
          left[mown]--;
          if (left[mown] > 0 && $urandom_range(0, 3) != 0) begin
            cw[mown] = 16'($urandom);
            cu[mown] = 8'($urandom);
          end else begin
            v[mown] = 1'b0;
          end
          if (lastw) begin
            mlo = mown;
            mown = -1;
            free_at = cyc + 1 + GAPX;
          end
        end else if (mown < 0 && cyc >= free_at && vm != '0) begin
          mown = rr(mlo, vm);
        end
        tick();
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
